tx_frame_packer: RTL and testbench
==================================

Name: tx_frame_packer

Overview:
Downstream consumer of the 125 MHz byte strobes produced by the clock-crossing stage. Collects single-byte writes (action_1/data_out_1) into a FIFO and cuts them into frames of FRAME_LEN bytes, or shorter frames on a flush strobe (action_2). Frames are short-padded to MIN_LEN and emitted as a valid/ready byte stream with SOF/EOF markers toward the TX MAC. Enforces an inter-frame gap between frames.

Parameters:
DEPTH, 128, FIFO depth in bytes; power of 2, >= FRAME_LEN
FRAME_LEN, 64, bytes per size-triggered frame; 1..DEPTH
MIN_LEN, 46, minimum emitted frame length; shorter frames are zero-padded; 0 disables padding
IFG_CYCLES, 12, idle cycles after each EOF handshake; >= 1

Ports:
clk_125  in  1  sole clock
reset  in  1  synchronous, active-high
byte_valid  in  1  one-cycle write strobe (from action_1)
byte_data  in  8  byte to store when byte_valid=1
flush  in  1  one-cycle strobe (from action_2); closes the current partial frame
out_valid  out  1  stream byte valid
out_ready  in  1  sink accepts byte when out_valid&&out_ready
out_data  out  8  stream byte
out_sof  out  1  first byte of frame, qualified by out_valid
out_eof  out  1  last byte of frame, qualified by out_valid
busy  out  1  state != IDLE
overflow  out  1  sticky: a byte was dropped on full FIFO; cleared only by reset
drop_count  out  8  dropped-byte counter, saturates at 255

Behaviour:
- Reset (synchronous, active-high): state=IDLE; FIFO pointers, fill count, pending_cnt, flush_pend, gap counter, overflow and drop_count cleared; all outputs 0. Reset mid-frame aborts it: out_valid is 0 the next cycle, no EOF is issued, and buffered bytes are discarded.
- Write: byte_valid && !full -> byte stored at the edge, fill+1, pending_cnt+1. byte_valid && full -> byte dropped, overflow<=1, drop_count+1 (saturating). Simultaneous write and read are allowed; fill is net unchanged. Full means fill==DEPTH and is evaluated before that cycle's read.
- pending_cnt counts bytes stored but not yet assigned to a frame (0..DEPTH).
- flush: sets flush_pend. flush_pend is consumed at commit. It is cleared without effect if evaluated in IDLE with pending_cnt==0.
- Commit happens only in IDLE and uses registered values:
  - If pending_cnt >= FRAME_LEN: frame_len=FRAME_LEN; flush_pend is retained.
  - Else if flush_pend && pending_cnt>0: frame_len=pending_cnt; flush_pend cleared.
  - pending_cnt -= frame_len. A same-cycle write adds on top.
  - Next state is SEND.
- Latency: the byte completing a frame is written at edge E. The commit occurs at edge E+1, and out_valid is high from E+1 with SOF=1.
- States:
  - IDLE: out_valid=0. Commits as above.
  - SEND: out_valid=1; out_data=FIFO head (asynchronous read); out_sof on the first byte; out_eof on the last byte when frame_len >= MIN_LEN. Each handshake pops one byte and increments the byte index. Last data byte accepted -> PAD if frame_len < MIN_LEN, else GAP.
  - PAD: out_valid=1, out_data=0x00. out_eof on byte index MIN_LEN-1. That handshake -> GAP.
  - GAP: out_valid=0 for exactly IFG_CYCLES cycles, then IDLE.
- Stream rule: while out_valid=1 and out_ready=0, out_valid, out_data, out_sof and out_eof hold stable. The only exception is reset.
- Single-byte frame with MIN_LEN=0: out_sof=out_eof=1 on the same byte.
- The FIFO wraps modulo DEPTH; pointers are log2(DEPTH) bits and fill is log2(DEPTH)+1 bits.
- Writes continue in every state, including during SEND, PAD and GAP.

Decomposition:
- Package tx_frame_pkg: state enum (IDLE, SEND, PAD, GAP), default parameter constants, PAD_BYTE=8'h00.
- Sub-module byte_fifo: single clock, DEPTH x 8, asynchronous read head, push/pop/full/empty/fill. The packer holds the FSM, pending_cnt, flush_pend and status counters.

Test Plan:
1. Write 64 bytes 0x00..0x3F, out_ready=1 -> one frame of 64 bytes 0x00..0x3F; SOF on 0x00, EOF on 0x3F; out_valid first high 1 cycle after the 64th write; then 12 idle cycles.
2. Write 5 bytes 0xA1..0xA5, then flush -> 46-byte frame: 0xA1..0xA5 followed by 41 x 0x00; EOF on byte 46; pending_cnt=0 afterwards.
3. Flush with the FIFO empty -> no frame, busy stays 0. A later single write of 0x11 plus flush -> padded 46-byte frame starting 0x11.
4. out_ready toggled randomly during a 64-byte frame -> sink receives the bytes in order; outputs stable while stalled; exactly one SOF and one EOF.
5. out_ready=0 while writing 130 bytes -> 128 stored; overflow=1, drop_count=2. Releasing out_ready -> two 64-byte frames, the second starting after the 12-cycle gap.
6. Reset asserted mid-SEND (byte 10 of 64) -> out_valid=0 the next cycle, no EOF, all counters 0. New writes after reset form a clean frame.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// Shared types and default sizing for the TX frame packer.
// The FSM sequences IDLE -> SEND -> (PAD) -> GAP -> IDLE.
package tx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAD  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int DEF_DEPTH      = 128;
  localparam int DEF_FRAME_LEN  = 64;
  localparam int DEF_MIN_LEN    = 46;
  localparam int DEF_IFG_CYCLES = 12;

  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/tx_frame_packer_fifo.sv
// Single-clock DEPTH x 8 byte FIFO with an asynchronous (fall-through) read head.
// A push is refused when full even if a pop happens in the same cycle.
module byte_fifo
  import tx_frame_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (fill_q == CW'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // storage array carries data only, so it is never reset
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/tx_frame_packer.sv
// Cuts a byte-strobe stream into FRAME_LEN frames (or shorter on flush), zero-pads
// short frames to MIN_LEN and emits them as a valid/ready stream with SOF/EOF.
module tx_frame_packer
  import tx_frame_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int MIN_LEN    = DEF_MIN_LEN,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES
) (
  input  logic       clk_125,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(DEPTH + MIN_LEN + 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] pending_q, pending_d;
  logic          flush_pend_q, flush_pend_d;
  logic [CW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_fill;
  logic          pop_req;
  logic          pop;
  logic          wr_acc;
  logic          last_data;
  logic          flush_clr;
  logic [CW-1:0] commit_len;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_125),
    .rst_i   (reset),
    .push_i  (byte_valid),
    .data_i  (byte_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fifo_fill)
  );

  assign wr_acc     = byte_valid && !fifo_full;
  assign pop        = pop_req && !fifo_empty;
  assign last_data  = (idx_q == IW'(len_q) - IW'(1));
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    pop_req      = 1'b0;
    flush_clr    = 1'b0;
    commit_len   = '0;
    out_valid    = 1'b0;
    out_data     = 8'h00;
    out_sof      = 1'b0;
    out_eof      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // commit decisions use only registered counts; this cycle's write lands afterwards
        if (pending_q >= CW'(FRAME_LEN)) begin
          commit_len = CW'(FRAME_LEN);
        end else if (flush_pend_q && (pending_q != '0)) begin
          commit_len = pending_q;
          flush_clr  = 1'b1;
        end else if (flush_pend_q) begin
          flush_clr  = 1'b1;
        end
        if ((commit_len != '0) && (fifo_fill >= commit_len)) begin
          len_d   = commit_len;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        out_valid = 1'b1;
        out_data  = fifo_head;
        out_sof   = (idx_q == '0);
        out_eof   = last_data && (int'(len_q) >= MIN_LEN);
        if (out_ready) begin
          pop_req = 1'b1;
          idx_d   = idx_q + IW'(1);
          if (last_data) begin
            if (int'(len_q) < MIN_LEN) begin
              state_d = PAD;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
        end
      end

      PAD: begin
        out_valid = 1'b1;
        out_data  = PAD_BYTE;
        out_eof   = (idx_q == IW'(MIN_LEN - 1));
        if (out_ready) begin
          idx_d = idx_q + IW'(1);
          if (out_eof) begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end

      GAP: begin
        if (gap_q == GW'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // frame assignment only ever happens in IDLE, so commit_len is zero elsewhere
    pending_d    = pending_q - (state_q == IDLE ? len_commit_mask(commit_len) : '0) + CW'(wr_acc);
    flush_pend_d = flush_clr ? 1'b0 : flush_pend_q;
    if (flush) flush_pend_d = 1'b1;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (byte_valid && fifo_full) begin
      overflow_d = 1'b1;
      drop_d     = sat_inc8(drop_q);
    end
  end

  function automatic logic [CW-1:0] len_commit_mask(input logic [CW-1:0] l);
    return (fifo_fill >= l) ? l : '0;
  endfunction

  always_ff @(posedge clk_125) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      flush_pend_q <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      overflow_q   <= 1'b0;
      drop_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      flush_pend_q <= flush_pend_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Directed bench for tx_frame_packer: a scoreboard queue holds the expected stream
// bytes pushed with each stimulus step and a negedge monitor pops and compares them.
module tb_tx_frame_packer;

  localparam int DEPTH = 128;
  localparam int FL    = 64;
  localparam int MINL  = 46;
  localparam int IFG   = 12;

  logic       clk_125 = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_count;

  always #4 clk_125 = ~clk_125;

  tx_frame_packer #(
    .DEPTH      (DEPTH),
    .FRAME_LEN  (FL),
    .MIN_LEN    (MINL),
    .IFG_CYCLES (IFG)
  ) dut (
    .clk_125    (clk_125),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t sb_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   rx_cnt  = 0;
  int   eof_cyc = -1000;
  int   sof_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream for a frame of n payload bytes start, start+1, ... padded to MINL.
  task automatic expect_frame(input logic [7:0] start, input int n);
    int total;
    exp_t e;
    total = (n < MINL) ? MINL : n;
    for (int k = 0; k < total; k++) begin
      e.d   = (k < n) ? 8'(int'(start) + k) : 8'h00;
      e.sof = (k == 0);
      e.eof = (k == total - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic write_bytes(input logic [7:0] start, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(int'(start) + i);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk_125); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk_125); #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input bit rnd);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(posedge clk_125); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    check("drain_timeout", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic wait_idle(input int max_cyc, output int idle_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk_125); #1;
      n++;
    end
    idle_cyc = cyc;
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    forever begin
      @(posedge clk_125);
      cyc++;
    end
  end

  // Monitor: scoreboard compare on each handshake plus hold-while-stalled checks.
  initial begin
    exp_t e;
    bit         stall;
    logic [7:0] pd;
    logic       ps, pe;
    stall = 1'b0;
    pd = 8'h00; ps = 1'b0; pe = 1'b0;
    forever begin
      @(negedge clk_125);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(out_valid), 32'(1));
          check("hold_data",  32'(out_data),  32'(pd));
          check("hold_sof",   32'(out_sof),   32'(ps));
          check("hold_eof",   32'(out_eof),   32'(pe));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_byte", 32'(sb_q.size()), 32'(1));
          end else begin
            e = sb_q.pop_front();
            check("byte_data", 32'(out_data), 32'(e.d));
            check("byte_sof",  32'(out_sof),  32'(e.sof));
            check("byte_eof",  32'(out_eof),  32'(e.eof));
          end
          rx_cnt++;
          if (out_sof) sof_gap = cyc - eof_cyc;
          if (out_eof) eof_cyc = cyc;
        end
        stall = out_valid && !out_ready;
        pd = out_data; ps = out_sof; pe = out_eof;
      end
    end
  end

  initial begin
    int idle_cyc;
    int base;
    int n;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    flush      = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk_125);
    #1;
    check("rst_valid", 32'(out_valid),  32'(0));
    check("rst_busy",  32'(busy),       32'(0));
    check("rst_ovf",   32'(overflow),   32'(0));
    check("rst_drop",  32'(drop_count), 32'(0));
    check("rst_sof",   32'(out_sof),    32'(0));
    check("rst_eof",   32'(out_eof),    32'(0));
    check("rst_data",  32'(out_data),   32'(0));
    reset = 1'b0;
    @(posedge clk_125); #1;

    // 1: full-size frame, latency and inter-frame gap
    expect_frame(8'h00, FL);
    write_bytes(8'h00, FL, 1'b0);
    check("t1_valid_before_commit", 32'(out_valid), 32'(0));
    @(posedge clk_125); #1;
    check("t1_valid_after_commit", 32'(out_valid), 32'(1));
    check("t1_first_sof",          32'(out_sof),   32'(1));
    check("t1_first_data",         32'(out_data),  32'(8'h00));
    wait_drain(300, 1'b0);
    wait_idle(100, idle_cyc);
    check("t1_gap_len", 32'(idle_cyc - eof_cyc), 32'(IFG + 1));

    // 2: short flushed frame padded to MIN_LEN
    expect_frame(8'hA1, 5);
    write_bytes(8'hA1, 5, 1'b0);
    do_flush();
    wait_drain(300, 1'b0);
    wait_idle(100, idle_cyc);
    repeat (5) @(posedge clk_125);
    #1;
    check("t2_no_residual_frame", 32'(busy), 32'(0));

    // 3: flush on empty FIFO is ignored, then a single-byte frame
    do_flush();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_125); #1;
      check("t3_empty_flush_busy",  32'(busy),      32'(0));
      check("t3_empty_flush_valid", 32'(out_valid), 32'(0));
    end
    expect_frame(8'h11, 1);
    write_bytes(8'h11, 1, 1'b0);
    do_flush();
    wait_drain(300, 1'b0);
    wait_idle(100, idle_cyc);

    // 4: random back-pressure across a frame
    expect_frame(8'h80, FL);
    write_bytes(8'h80, FL, 1'b1);
    wait_drain(2000, 1'b1);
    wait_idle(100, idle_cyc);

    // 5: overflow while stalled, then two back-to-back frames
    out_ready = 1'b0;
    expect_frame(8'h00, FL);
    expect_frame(8'h40, FL);
    write_bytes(8'h00, 130, 1'b0);
    check("t5_overflow", 32'(overflow),   32'(1));
    check("t5_drops",    32'(drop_count), 32'(2));
    out_ready = 1'b1;
    wait_drain(500, 1'b0);
    check("t5_second_sof_gap", 32'(sof_gap), 32'(IFG + 2));
    wait_idle(100, idle_cyc);

    // 6: reset in the middle of a frame
    expect_frame(8'h20, FL);
    write_bytes(8'h20, FL, 1'b0);
    base = rx_cnt;
    n = 0;
    while (rx_cnt < base + 10 && n < 200) begin
      @(posedge clk_125); #1;
      n++;
    end
    check("t6_reach_byte10", 32'(rx_cnt - base), 32'(10));
    reset = 1'b1;
    @(posedge clk_125); #1;
    sb_q.delete();
    check("t6_valid", 32'(out_valid),  32'(0));
    check("t6_eof",   32'(out_eof),    32'(0));
    check("t6_busy",  32'(busy),       32'(0));
    check("t6_ovf",   32'(overflow),   32'(0));
    check("t6_drop",  32'(drop_count), 32'(0));
    reset = 1'b0;
    @(posedge clk_125); #1;
    expect_frame(8'hC0, FL);
    write_bytes(8'hC0, FL, 1'b0);
    wait_drain(300, 1'b0);
    wait_idle(100, idle_cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
